// File: rtl/acc_delta_monitor_if.sv
// acc_delta_monitor_if: sample input, delta output and status bundle for acc_delta_monitor
interface acc_delta_monitor_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
);
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic                     out_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic [CNTW-1:0]          drop_cnt;
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, level, overflow, drop_cnt
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, level, overflow, drop_cnt
    );
endinterface

// File: rtl/acc_delta_monitor.sv
// acc_delta_monitor: successive differences of accumulator samples, buffered in a FIFO with drop counting
module acc_delta_monitor #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input logic                clk,
    input logic                rst,
    acc_delta_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    typedef enum logic {PRIME, RUN} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNTW-1:0]  drop_q, drop_d;
    logic             push, pop, full, wr_en, drop;
    always_comb begin
        pop        = (level_q != '0) & bus.out_ready;
        push       = (state_q == RUN) & bus.in_valid;
        full       = level_q == FULL_LVL;
        wr_en      = push & (~full | pop);
        drop       = push & full & ~pop;
        state_d    = bus.in_valid ? RUN : state_q;
        prev_d     = bus.in_valid ? bus.in_data : prev_q;
        wr_d       = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        level_d    = (wr_en & ~pop) ? level_q + 1'b1 : (pop & ~wr_en) ? level_q - 1'b1 : level_q;
        overflow_d = overflow_q | drop;
        drop_d     = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PRIME;
            prev_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end
    // Storage needs no reset: pointers and level gate every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= bus.in_data - prev_q;
    end
    assign bus.out_valid = level_q != '0;
    assign bus.out_data  = mem_q[rd_q];
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_acc_delta_monitor.sv
// tb_acc_delta_monitor: directed-vector bench for acc_delta_monitor
module tb_acc_delta_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    acc_delta_monitor_if #(.WIDTH(32), .DEPTH(8), .CNTW(16)) bus ();
    acc_delta_monitor #(.WIDTH(32), .DEPTH(8), .CNTW(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        vectors++;
        if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        vectors++;
        if (bus.drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d want 0", bus.drop_cnt); end
    endtask
    task automatic test_stream;
        logic [31:0] s [7] = '{0, 0, 0, 1, 3, 6, 10};
        logic [31:0] d [6] = '{0, 0, 1, 2, 3, 4};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = s[i];
            step();
            vectors++;
            if (i == 0) begin
                if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_prime: got out_valid=%b want 0", bus.out_valid); end
            end else if (bus.out_valid !== 1'b1 || bus.out_data !== d[i-1]) begin
                miscompares++;
                $display("FAIL stream_delta%0d: got valid=%b data=%0d want valid=1 data=%0d", i, bus.out_valid, bus.out_data, d[i-1]);
            end
            vectors++;
            if (bus.level > 4'd1) begin miscompares++; $display("FAIL stream_level%0d: got %0d want <=1", i, bus.level); end
        end
        bus.in_valid = 1'b0;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drained: got out_valid=%b want 0", bus.out_valid); end
    endtask
    task automatic test_gaps_wrap;
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hFFFF_FFFE;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_idle%0d: got out_valid=%b want 0", i, bus.out_valid); end
            if (i < 3) step();
        end
        bus.in_valid = 1'b1;
        bus.in_data = 32'h0000_0001;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd3) begin
            miscompares++;
            $display("FAIL wrap_delta: got valid=%b data=%0h want valid=1 data=3", bus.out_valid, bus.out_data);
        end
        vectors++;
        if (bus.level !== 4'd1) begin miscompares++; $display("FAIL wrap_level: got %0d want 1", bus.level); end
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_no_extra: got out_valid=%b want 0", bus.out_valid); end
    endtask
    task automatic test_overflow;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = i;
            step();
            if (i == 8) begin
                vectors++;
                if (bus.level !== 4'd8 || bus.overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_full: got level=%0d overflow=%b want level=8 overflow=0", bus.level, bus.overflow);
                end
            end
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.level !== 4'd8) begin miscompares++; $display("FAIL ovf_level: got %0d want 8", bus.level); end
        vectors++;
        if (bus.overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        vectors++;
        if (bus.drop_cnt !== 16'd1) begin miscompares++; $display("FAIL ovf_drop_cnt: got %0d want 1", bus.drop_cnt); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1) begin
                miscompares++;
                $display("FAIL ovf_drain%0d: got valid=%b data=%0d want valid=1 data=1", i, bus.out_valid, bus.out_data);
            end
            step();
        end
        vectors++;
        if (bus.level !== 4'd0) begin miscompares++; $display("FAIL ovf_empty: got level=%0d want 0", bus.level); end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd20;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd11) begin
            miscompares++;
            $display("FAIL ovf_prev_tracked: got valid=%b data=%0d want valid=1 data=11", bus.out_valid, bus.out_data);
        end
    endtask
    task automatic test_full_push_pop;
        bus.out_ready = 1'b0;
        for (int i = 21; i <= 27; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = i;
            step();
        end
        vectors++;
        if (bus.level !== 4'd8 || bus.out_data !== 32'd11) begin
            miscompares++;
            $display("FAIL fpp_pre: got level=%0d head=%0d want level=8 head=11", bus.level, bus.out_data);
        end
        bus.in_data = 32'd30;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.level !== 4'd8) begin miscompares++; $display("FAIL fpp_level: got %0d want 8", bus.level); end
        vectors++;
        if (bus.drop_cnt !== 16'd1) begin miscompares++; $display("FAIL fpp_drop_cnt: got %0d want 1", bus.drop_cnt); end
        vectors++;
        if (bus.out_data !== 32'd1) begin miscompares++; $display("FAIL fpp_head: got %0d want 1", bus.out_data); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] want;
            want = (i == 7) ? 32'd3 : 32'd1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== want) begin
                miscompares++;
                $display("FAIL fpp_order%0d: got valid=%b data=%0d want valid=1 data=%0d", i, bus.out_valid, bus.out_data, want);
            end
            step();
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fpp_empty: got out_valid=%b want 0", bus.out_valid); end
    endtask
    task automatic test_mid_reset;
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 100; i <= 105; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = i;
            step();
        end
        vectors++;
        if (bus.level !== 4'd5) begin miscompares++; $display("FAIL mrst_pre_level: got %0d want 5", bus.level); end
        rst = 1'b1;
        bus.in_data = 32'd999;
        step();
        rst = 1'b0;
        vectors++;
        if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_cleared: got level=%0d valid=%b want level=0 valid=0", bus.level, bus.out_valid);
        end
        bus.in_data = 32'd200;
        step();
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_prime: got out_valid=%b want 0", bus.out_valid); end
        bus.in_data = 32'd207;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd7) begin
            miscompares++;
            $display("FAIL mrst_first_delta: got valid=%b data=%0d want valid=1 data=7", bus.out_valid, bus.out_data);
        end
    endtask
    initial begin
        test_reset();
        test_stream();
        test_gaps_wrap();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
